// File: rtl/led_info_seq_if.sv
// -----------------------------------------------------------------------------
// led_info_seq_if
// Control handshake bundle for led_info_seq.
//   start_i : one-cycle request to display one build record
//   sel_i   : record select (0 scripts, 1 top, 2 common, 3 invalid)
//   busy_o  : high while a record is being displayed
//   done_o  : one-cycle pulse when a record completes
//   err_o   : one-cycle pulse when a start request is rejected
// The master modport is the requester; the slave modport is led_info_seq.
// -----------------------------------------------------------------------------
interface led_info_seq_if;
   logic       start_i;
   logic [1:0] sel_i;
   logic       busy_o;
   logic       done_o;
   logic       err_o;

   modport master (
      output start_i,
      output sel_i,
      input  busy_o,
      input  done_o,
      input  err_o
   );

   modport slave (
      input  start_i,
      input  sel_i,
      output busy_o,
      output done_o,
      output err_o
   );
endinterface

// File: rtl/led_info_seq.sv
// -----------------------------------------------------------------------------
// led_info_seq
// Blinks one build record (64-bit git hash + 32-bit timestamp) out on two
// 3-bit LED groups, one frame per rising edge of a slow blink source.
// Frame sequence: header (all on) x HDR_TICKS, 16 hash nibbles MSB first,
// blank x GAP_TICKS, 8 timestamp nibbles MSB first, then a one-cycle finish.
//
// Ports
//   clk100                : sole clock, rising edge
//   rst                   : synchronous active-high reset
//   tick_i                : blink source level; each rising edge is a step
//   git_hash_*_i          : 64-bit build hashes (scripts / top / common)
//   timestamp_*_i         : 32-bit build timestamps (scripts / top / common)
//   led_0                 : {frame, phase, nib[3]}
//   led_1                 : nib[2:0]
//   ctrl                  : start/sel request, busy/done/err status
//
// Optional feature macro: LED_INFO_AUTO_EN
//   When defined, the block starts a record on its own after reset and after
//   every finish, cycling sel 0 -> 1 -> 2 -> 0; start_i is ignored and err_o
//   stays low.
// -----------------------------------------------------------------------------
module led_info_seq #(
   parameter int HDR_TICKS = 2,
   parameter int GAP_TICKS = 1
) (
   input  logic          clk100,
   input  logic          rst,
   input  logic          tick_i,
   input  logic [63:0]   git_hash_scripts_i,
   input  logic [63:0]   git_hash_top_i,
   input  logic [63:0]   git_hash_common_i,
   input  logic [31:0]   timestamp_scripts_i,
   input  logic [31:0]   timestamp_top_i,
   input  logic [31:0]   timestamp_common_i,
   output logic [2:0]    led_0,
   output logic [2:0]    led_1,
   led_info_seq_if.slave ctrl
);

   localparam logic [2:0] LP_HDR_TICKS = 3'(HDR_TICKS);
   localparam logic [2:0] LP_GAP_TICKS = 3'(GAP_TICKS);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_HASH = 3'd2,
      S_GAP  = 3'd3,
      S_TS   = 3'd4,
      S_FIN  = 3'd5
   } state_t;

   // State and datapath registers
   state_t      r_state;
   logic        r_tick;
   logic        r_rst_d;
   logic [95:0] r_shift;
   logic [2:0]  r_tick_cnt;
   logic [4:0]  r_nib_cnt;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic [2:0]  r_led_0;
   logic [2:0]  r_led_1;

   // Combinational next values
   state_t      w_state_nxt;
   logic [95:0] w_shift_nxt;
   logic [2:0]  w_tick_cnt_nxt;
   logic [4:0]  w_nib_cnt_nxt;
   logic [2:0]  w_led_0_nxt;
   logic [2:0]  w_led_1_nxt;
   logic        w_busy_nxt;
   logic        w_done_nxt;
   logic        w_err_nxt;
   logic [3:0]  w_nib;
   logic [95:0] w_snap;
   logic        w_step;
   logic        w_start;
   logic [1:0]  w_sel;
   logic        w_launch;

   // The first cycle after reset is masked so an edge already present when
   // reset releases does not count as a step.
   assign w_step   = tick_i & ~r_tick & ~r_rst_d;
   assign w_launch = (r_state == S_IDLE) && w_start && (w_sel != 2'd3);

`ifdef LED_INFO_AUTO_EN
   logic [1:0] r_auto_sel;
   logic       w_unused_ctrl;

   assign w_start       = 1'b1;
   assign w_sel         = r_auto_sel;
   assign w_err_nxt     = 1'b0;
   assign w_unused_ctrl = ^{ctrl.start_i, ctrl.sel_i};

   // Auto-select rotates 0 -> 1 -> 2 -> 0 on every launched record
   always_ff @(posedge clk100) begin
      if (rst) begin
         r_auto_sel <= 2'd0;
      end else if (w_launch) begin
         r_auto_sel <= (r_auto_sel == 2'd2) ? 2'd0 : (r_auto_sel + 2'd1);
      end else begin
         r_auto_sel <= r_auto_sel;
      end
   end
`else
   assign w_start   = ctrl.start_i;
   assign w_sel     = ctrl.sel_i;
   // Rejected when a record is already running or the select is invalid
   assign w_err_nxt = ctrl.start_i && ((r_state != S_IDLE) || (ctrl.sel_i == 2'd3));
`endif

   // Snapshot source: hash in the upper 64 bits so it shifts out first
   always_comb begin
      case (w_sel)
         2'd0:    w_snap = {git_hash_scripts_i, timestamp_scripts_i};
         2'd1:    w_snap = {git_hash_top_i,     timestamp_top_i};
         2'd2:    w_snap = {git_hash_common_i,  timestamp_common_i};
         default: w_snap = 96'd0;
      endcase
   end

   // Next-state and datapath update logic
   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_tick_cnt_nxt = r_tick_cnt;
      w_nib_cnt_nxt  = r_nib_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_launch) begin
               w_state_nxt    = S_HDR;
               w_shift_nxt    = w_snap;
               w_tick_cnt_nxt = LP_HDR_TICKS;
               w_nib_cnt_nxt  = 5'd0;
            end else begin
               w_state_nxt    = S_IDLE;
            end
         end
         S_HDR: begin
            if (w_step) begin
               if (r_tick_cnt == 3'd1) begin
                  w_state_nxt    = S_HASH;
                  w_tick_cnt_nxt = 3'd0;
               end else begin
                  w_tick_cnt_nxt = r_tick_cnt - 3'd1;
               end
            end else begin
               w_state_nxt = S_HDR;
            end
         end
         S_HASH: begin
            // Every hash step moves the next nibble into the top slot; after
            // 16 shifts the timestamp sits at the top.
            if (w_step) begin
               w_shift_nxt = {r_shift[91:0], 4'h0};
               if (r_nib_cnt == 5'd15) begin
                  w_state_nxt    = S_GAP;
                  w_nib_cnt_nxt  = 5'd0;
                  w_tick_cnt_nxt = LP_GAP_TICKS;
               end else begin
                  w_nib_cnt_nxt  = r_nib_cnt + 5'd1;
               end
            end else begin
               w_state_nxt = S_HASH;
            end
         end
         S_GAP: begin
            if (w_step) begin
               if (r_tick_cnt == 3'd1) begin
                  w_state_nxt    = S_TS;
                  w_tick_cnt_nxt = 3'd0;
               end else begin
                  w_tick_cnt_nxt = r_tick_cnt - 3'd1;
               end
            end else begin
               w_state_nxt = S_GAP;
            end
         end
         S_TS: begin
            if (w_step) begin
               w_shift_nxt = {r_shift[91:0], 4'h0};
               if (r_nib_cnt == 5'd7) begin
                  w_state_nxt   = S_FIN;
                  w_nib_cnt_nxt = 5'd0;
               end else begin
                  w_nib_cnt_nxt = r_nib_cnt + 5'd1;
               end
            end else begin
               w_state_nxt = S_TS;
            end
         end
         S_FIN: begin
            w_state_nxt    = S_IDLE;
            w_shift_nxt    = 96'd0;
            w_tick_cnt_nxt = 3'd0;
            w_nib_cnt_nxt  = 5'd0;
         end
         default: begin
            w_state_nxt    = S_IDLE;
            w_shift_nxt    = 96'd0;
            w_tick_cnt_nxt = 3'd0;
            w_nib_cnt_nxt  = 5'd0;
         end
      endcase
   end

   // Output decode from the next state so the LEDs change on the same edge
   // as the state they describe
   always_comb begin
      w_nib       = w_shift_nxt[95:92];
      w_led_0_nxt = 3'd0;
      w_led_1_nxt = 3'd0;
      case (w_state_nxt)
         S_HDR: begin
            w_led_0_nxt = 3'b111;
            w_led_1_nxt = 3'b111;
         end
         S_HASH: begin
            w_led_0_nxt = {1'b1, 1'b0, w_nib[3]};
            w_led_1_nxt = w_nib[2:0];
         end
         S_TS: begin
            w_led_0_nxt = {1'b1, 1'b1, w_nib[3]};
            w_led_1_nxt = w_nib[2:0];
         end
         default: begin
            w_led_0_nxt = 3'd0;
            w_led_1_nxt = 3'd0;
         end
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE);
      w_done_nxt = (w_state_nxt == S_FIN);
   end

   // State, datapath and registered output update
   always_ff @(posedge clk100) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_tick     <= 1'b0;
         r_rst_d    <= 1'b1;
         r_shift    <= 96'd0;
         r_tick_cnt <= 3'd0;
         r_nib_cnt  <= 5'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_led_0    <= 3'd0;
         r_led_1    <= 3'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_tick     <= tick_i;
         r_rst_d    <= 1'b0;
         r_shift    <= w_shift_nxt;
         r_tick_cnt <= w_tick_cnt_nxt;
         r_nib_cnt  <= w_nib_cnt_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_err      <= w_err_nxt;
         r_led_0    <= w_led_0_nxt;
         r_led_1    <= w_led_1_nxt;
      end
   end

   assign led_0       = r_led_0;
   assign led_1       = r_led_1;
   assign ctrl.busy_o = r_busy;
   assign ctrl.done_o = r_done;
   assign ctrl.err_o  = r_err;

endmodule

// File: tb/tb_led_info_seq.sv
// -----------------------------------------------------------------------------
// tb_led_info_seq
// Scoreboard bench for led_info_seq. Each driven cycle runs a frame-list
// reference model that predicts the outputs after the next clock edge and
// queues them tagged with that edge number; an independent monitor pops and
// compares at each falling edge.
// -----------------------------------------------------------------------------
module tb_led_info_seq;
   localparam int HDR_TICKS = 2;
   localparam int GAP_TICKS = 1;

   logic        clk100 = 1'b0;
   logic        rst;
   logic        tick_i;
   logic [63:0] hash_s, hash_t, hash_c;
   logic [31:0] ts_s, ts_t, ts_c;
   logic [2:0]  led_0, led_1;

   led_info_seq_if ctrl_if ();

   led_info_seq #(.HDR_TICKS(HDR_TICKS), .GAP_TICKS(GAP_TICKS)) dut (
      .clk100              (clk100),
      .rst                 (rst),
      .tick_i              (tick_i),
      .git_hash_scripts_i  (hash_s),
      .git_hash_top_i      (hash_t),
      .git_hash_common_i   (hash_c),
      .timestamp_scripts_i (ts_s),
      .timestamp_top_i     (ts_t),
      .timestamp_common_i  (ts_c),
      .led_0               (led_0),
      .led_1               (led_1),
      .ctrl                (ctrl_if.slave)
   );

   always #5 clk100 = ~clk100;

   // expected vector: {led_0, led_1, busy, done, err}
   typedef struct {
      int unsigned edge_no;
      logic [8:0]  exp;
   } exp_item_t;

   exp_item_t   exp_q[$];
   int unsigned n_edges = 0;
   int          n_err = 0;
   int          n_checks = 0;
   bit          rnd_data = 1'b0;

   // Reference model state
   int          m_phase = 0;   // 0 idle, 1 displaying frames, 2 finish cycle
   logic [5:0]  m_frames[$];
   int          m_pos = 0;
   bit          m_tick_q = 1'b0;
   bit          m_rst_q = 1'b0;
   int          m_auto_sel = 0;

   always @(posedge clk100) n_edges <= n_edges + 1;

   // Frame list of a record: {led_0, led_1} per step interval
   task automatic build_frames(input logic [63:0] h, input logic [31:0] t);
      logic [3:0] n;
      m_frames.delete();
      for (int i = 0; i < HDR_TICKS; i++) m_frames.push_back(6'b111111);
      for (int i = 0; i < 16; i++) begin
         n = 4'((h >> (60 - 4 * i)) & 64'hF);
         m_frames.push_back({2'b10, n});
      end
      for (int i = 0; i < GAP_TICKS; i++) m_frames.push_back(6'b000000);
      for (int i = 0; i < 8; i++) begin
         n = 4'((t >> (28 - 4 * i)) & 32'hF);
         m_frames.push_back({2'b11, n});
      end
   endtask

   // Predict outputs after the coming clock edge
   task automatic model_edge(input bit r, input bit t, input bit s,
                             input logic [1:0] sl, output logic [8:0] e);
      bit step, err, st;
      int sel_e;
      if (r) begin
         m_phase = 0; m_tick_q = 1'b0; m_rst_q = 1'b1; m_auto_sel = 0;
         e = 9'd0;
         return;
      end
      step = t && !m_tick_q && !m_rst_q;
      m_tick_q = t;
      m_rst_q = 1'b0;
      err = 1'b0;
      st = s;
      sel_e = int'(sl);
`ifdef LED_INFO_AUTO_EN
      st = 1'b1;
      sel_e = m_auto_sel;
`endif
      case (m_phase)
         0: if (st) begin
               if (sel_e == 3) err = 1'b1;
               else begin
                  case (sel_e)
                     0: build_frames(hash_s, ts_s);
                     1: build_frames(hash_t, ts_t);
                     default: build_frames(hash_c, ts_c);
                  endcase
                  m_phase = 1; m_pos = 0;
                  m_auto_sel = (m_auto_sel + 1) % 3;
               end
            end
         1: begin
               if (st) err = 1'b1;
               if (step) begin
                  m_pos++;
                  if (m_pos == m_frames.size()) m_phase = 2;
               end
            end
         default: begin
               if (st) err = 1'b1;
               m_phase = 0;
            end
      endcase
`ifdef LED_INFO_AUTO_EN
      err = 1'b0;
`endif
      if (m_phase == 1)      e = {m_frames[m_pos], 1'b1, 1'b0, err};
      else if (m_phase == 2) e = {6'd0, 1'b1, 1'b1, err};
      else                   e = {6'd0, 1'b0, 1'b0, err};
   endtask

   // One cycle of stimulus; expectation queued for the next edge
   task automatic drive(input bit r, input bit t, input bit s, input logic [1:0] sl);
      logic [8:0] e;
      if (rnd_data && $urandom_range(0, 15) == 0) begin
         hash_s = {$urandom, $urandom}; hash_t = {$urandom, $urandom};
         hash_c = {$urandom, $urandom};
         ts_s = $urandom; ts_t = $urandom; ts_c = $urandom;
      end
      rst = r; tick_i = t; ctrl_if.start_i = s; ctrl_if.sel_i = sl;
      model_edge(r, t, s, sl, e);
      exp_q.push_back('{edge_no: n_edges + 1, exp: e});
      @(posedge clk100);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b1, 1'b0, 2'd0);
         drive(1'b0, 1'b0, 1'b0, 2'd0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 2'd0);
   endtask

   // Monitor: compare the DUT against the expectation for this edge
   always @(negedge clk100) begin : monitor
      exp_item_t  it;
      logic [8:0] act;
      while (exp_q.size() > 0 && exp_q[0].edge_no < n_edges) begin
         it = exp_q.pop_front();
         n_checks++; n_err++;
         $display("FAIL sb_stale: entry for edge %0d unchecked at edge %0d", it.edge_no, n_edges);
      end
      if (exp_q.size() > 0 && exp_q[0].edge_no == n_edges) begin
         it = exp_q.pop_front();
         act = {led_0, led_1, ctrl_if.busy_o, ctrl_if.done_o, ctrl_if.err_o};
         n_checks++;
         if (act !== it.exp) begin
            n_err++;
            $display("FAIL outputs edge %0d: got led0=%b led1=%b busy=%b done=%b err=%b, want led0=%b led1=%b busy=%b done=%b err=%b",
                     n_edges, act[8:6], act[5:3], act[2], act[1], act[0],
                     it.exp[8:6], it.exp[5:3], it.exp[2], it.exp[1], it.exp[0]);
         end
      end
   end

   initial begin
      bit cur_t;
      hash_s = 64'h1111_2222_3333_4444; ts_s = 32'h5566_7788;
      hash_t = 64'h0123_4567_89AB_CDEF; ts_t = 32'hDEAD_BEEF;
      hash_c = 64'hFEDC_BA98_7654_3210; ts_c = 32'h0F1E_2D3C;

      // reset state
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 2'd0);
      idle(2);
      steps(3);                              // steps in idle do nothing

      // reference record: top select, 27 steps
      drive(1'b0, 1'b0, 1'b1, 2'd1);
      steps(27);
      idle(3);

      // invalid select rejected
      drive(1'b0, 1'b0, 1'b1, 2'd3);
      idle(3);

      // start during hash phase rejected, record unchanged
      drive(1'b0, 1'b0, 1'b1, 2'd0);
      steps(6);
      drive(1'b0, 1'b0, 1'b1, 2'd2);
      steps(21);
      idle(3);

      // reset after the 5th hash nibble, then replay
      drive(1'b0, 1'b0, 1'b1, 2'd2);
      steps(HDR_TICKS + 5);
      drive(1'b1, 1'b0, 1'b0, 2'd0);
      idle(2);
      drive(1'b0, 1'b0, 1'b1, 2'd2);
      steps(27);
      idle(3);

      // tick held high for 50 cycles counts as one step
      drive(1'b0, 1'b0, 1'b1, 2'd1);
      for (int i = 0; i < 50; i++) drive(1'b0, 1'b1, 1'b0, 2'd0);
      idle(1);
      steps(26);
      idle(3);

      // randomized traffic with changing inputs during records
      rnd_data = 1'b1;
      cur_t = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 2) == 0) cur_t = ~cur_t;
         drive(($urandom_range(0, 499) == 0), cur_t,
               ($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)));
      end
      idle(3);

      // drain remaining expectations within a bounded number of cycles
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk100);
      @(negedge clk100);
      #1;
      if (exp_q.size() > 0) begin
         n_checks++; n_err++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/led_info_seq.md
LED_INFO_SEQ -- requirements
Module: led_info_seq

Interface
REQ-001 SHALL have parameter HDR_TICKS, default 2: number of step events spent in the header phase (range 1-7).
REQ-002 SHALL have parameter GAP_TICKS, default 1: number of blank step events between the hash and timestamp phases (range 1-7).
REQ-003 SHALL have port clk100  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port tick_i  in  1  level blink source; each rising edge is one step event.
REQ-006 SHALL have port start_i  in  1  one-cycle request to display one build record.
REQ-007 SHALL have port sel_i  in  2  record select: 0 scripts, 1 top, 2 common, 3 invalid.
REQ-008 SHALL have ports git_hash_scripts_i, git_hash_top_i, git_hash_common_i  in  64 each  build hashes.
REQ-009 SHALL have ports timestamp_scripts_i, timestamp_top_i, timestamp_common_i  in  32 each  build timestamps.
REQ-010 SHALL have port busy_o  out  1  high while a record is being displayed.
REQ-011 SHALL have port done_o  out  1  one-cycle pulse when a record completes.
REQ-012 SHALL have port err_o  out  1  one-cycle pulse when a start is rejected.
REQ-013 SHALL have port led_0  out  3  {frame, phase, nib[3]}.
REQ-014 SHALL have port led_1  out  3  nib[2:0].

Function
REQ-015 SHALL detect a step as tick_i=1 while its registered copy is 0; the state and LED update SHALL occur in the cycle after detection.
REQ-016 SHALL implement states IDLE, HDR, HASH, GAP, TS, FIN.
REQ-017 In IDLE with start_i=1 and sel_i<3, the block SHALL snapshot the selected 64-bit hash and 32-bit timestamp into a 96-bit shift register, load the tick counter with HDR_TICKS, enter HDR and assert busy_o on the next cycle.
REQ-018 In IDLE with start_i=1 and sel_i=3, the block SHALL pulse err_o for one cycle and remain in IDLE.
REQ-019 start_i while busy_o=1 SHALL be ignored and SHALL pulse err_o for one cycle.
REQ-020 HDR SHALL drive led_0=3'b111 and led_1=3'b111 for HDR_TICKS steps, then enter HASH.
REQ-021 HASH SHALL show 16 nibbles of the hash, MSB nibble first, one per step: led_0={1,0,nib[3]}, led_1=nib[2:0]; after the 16th step it SHALL enter GAP.
REQ-022 GAP SHALL drive all LEDs 0 for GAP_TICKS steps, then enter TS.
REQ-023 TS SHALL show 8 timestamp nibbles, MSB first: led_0={1,1,nib[3]}; after the 8th step it SHALL enter FIN.
REQ-024 FIN SHALL last one cycle: done_o=1, then IDLE with busy_o=0 and all LEDs 0.
REQ-025 Snapshotted data SHALL be unaffected by input changes during busy_o.
REQ-026 Step events in IDLE SHALL have no effect.
REQ-027 The nibble counter SHALL be 5 bits and SHALL never wrap within a phase.

Reset
REQ-028 rst=1 SHALL force IDLE, busy_o=0, done_o=0, err_o=0, led_0=0, led_1=0, counters and shift register 0, and the tick edge register 0, taking effect at the next clk100 edge.
REQ-029 rst asserted mid-record SHALL abort the record without a done_o pulse.
REQ-030 A step edge present in the cycle rst deasserts SHALL be ignored.

Configuration
REQ-031 With macro LED_INFO_AUTO_EN defined, the block SHALL self-start after reset and after every FIN, cycling sel 0->1->2->0; start_i SHALL be ignored and err_o SHALL stay 0.
REQ-032 Without LED_INFO_AUTO_EN, records SHALL start only via start_i as specified in REQ-017 to REQ-019.

Verification
REQ-033 Scenario: sel_i=1, git_hash_top_i=64'h0123_4567_89AB_CDEF, timestamp_top_i=32'hDEADBEEF, start, 27 steps -> 2 header frames, nibbles 0..F, 1 blank, nibbles D,E,A,D,B,E,E,F, then one done_o pulse.
REQ-034 Scenario: start_i with sel_i=3 -> one err_o pulse, busy_o stays 0.
REQ-035 Scenario: start_i during HASH -> one err_o pulse; the display sequence is unchanged.
REQ-036 Scenario: rst after the 5th hash nibble -> LEDs 0 and busy_o=0 next cycle, no done_o; a new start replays from the header.
REQ-037 Scenario: tick_i held high for 50 cycles -> exactly one step.
REQ-038 Scenario: LED_INFO_AUTO_EN defined, no start_i -> records for sel 0, 1, 2, 0 are displayed back to back.
